// File: rtl/mod_div_unit.sv
// Sequential modular divider: c = b * a^-1 mod m (odd m) via binary extended Euclid, one step per clock.
// Optional operand checking is compiled in when MOD_DIV_INPUT_CHECK_EN is defined.
module mod_div_unit #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] c,
  output logic             ready,
  output logic             busy,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] THREE = {{(WIDTH-2){1'b0}}, 2'b11};

  // Halve x modulo mv: an odd x gets mv added first, so the sum needs one extra bit.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] mv);
    logic [WIDTH:0] s;
    s = {1'b0, x} + (x[0] ? {1'b0, mv} : {(WIDTH+1){1'b0}});
    return WIDTH'(s >> 1);
  endfunction

  // x - y mod mv, assuming both are already reduced; wraparound absorbs the borrow.
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] mv);
    logic [WIDTH-1:0] d;
    d = x - y;
    return (x < y) ? (d + mv) : d;
  endfunction

  logic [1:0]       state_r, state_s;
  logic [WIDTH-1:0] u_r, u_s, v_r, v_s, x1_r, x1_s, x2_r, x2_s, mreg_r, mreg_s, c_r, c_s;
  logic             err_r, err_s, ready_r, ready_s, busy_r, busy_s, chk_r, chk_s;
  logic             bad_ops_s;

`ifdef MOD_DIV_INPUT_CHECK_EN
  assign bad_ops_s = ~m[0] | (m < THREE) | (a == ZERO) | (a >= m) | (b >= m);
`else
  assign bad_ops_s = 1'b0;
`endif

  // Next-state and datapath step for one reduction per cycle.
  always_comb begin
    state_s = state_r;
    u_s     = u_r;
    v_s     = v_r;
    x1_s    = x1_r;
    x2_s    = x2_r;
    mreg_s  = mreg_r;
    c_s     = c_r;
    err_s   = err_r;
    chk_s   = chk_r;
    busy_s  = busy_r;
    ready_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          u_s     = a;
          v_s     = m;
          x1_s    = b;
          x2_s    = ZERO;
          mreg_s  = m;
          c_s     = ZERO;
          err_s   = 1'b0;
          chk_s   = bad_ops_s;
          busy_s  = 1'b1;
          state_s = S_RUN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (chk_r || (u_r == ZERO) || (v_r == ZERO)) begin
          err_s   = 1'b1;
          c_s     = ZERO;
          busy_s  = 1'b0;
          ready_s = 1'b1;
          state_s = S_DONE;
        end else if (u_r == ONE) begin
          c_s     = x1_r;
          busy_s  = 1'b0;
          ready_s = 1'b1;
          state_s = S_DONE;
        end else if (v_r == ONE) begin
          c_s     = x2_r;
          busy_s  = 1'b0;
          ready_s = 1'b1;
          state_s = S_DONE;
        end else if (!u_r[0]) begin
          u_s  = u_r >> 1;
          x1_s = half_mod(x1_r, mreg_r);
        end else if (!v_r[0]) begin
          v_s  = v_r >> 1;
          x2_s = half_mod(x2_r, mreg_r);
        end else if (u_r >= v_r) begin
          u_s  = u_r - v_r;
          x1_s = sub_mod(x1_r, x2_r, mreg_r);
        end else begin
          v_s  = v_r - u_r;
          x2_s = sub_mod(x2_r, x1_r, mreg_r);
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      u_r     <= ZERO;
      v_r     <= ZERO;
      x1_r    <= ZERO;
      x2_r    <= ZERO;
      mreg_r  <= ZERO;
      c_r     <= ZERO;
      err_r   <= 1'b0;
      chk_r   <= 1'b0;
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      u_r     <= u_s;
      v_r     <= v_s;
      x1_r    <= x1_s;
      x2_r    <= x2_s;
      mreg_r  <= mreg_s;
      c_r     <= c_s;
      err_r   <= err_s;
      chk_r   <= chk_s;
      busy_r  <= busy_s;
      ready_r <= ready_s;
    end
  end

  assign c     = c_r;
  assign err   = err_r;
  assign busy  = busy_r;
  assign ready = ready_r;

endmodule

// File: tb/tb_mod_div_unit.sv
// Scoreboard bench for mod_div_unit: a 256-bit instance for directed cases, an 8-bit instance for a modulus-251 sweep.
module tb_mod_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, start8;
  logic [255:0] a, b, m, c;
  logic         ready, busy, err;
  logic [7:0]   a8, b8, m8, c8;
  logic         ready8, busy8, err8;

  mod_div_unit #(.WIDTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .m(m),
    .c(c), .ready(ready), .busy(busy), .err(err));

  mod_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .m(m8),
    .c(c8), .ready(ready8), .busy(busy8), .err(err8));

  typedef struct {
    logic [255:0] c;
    logic         err;
    int           acc;
    int           exact;
    int           maxc;
  } exp_t;

  exp_t sb[$];
  exp_t sb8[$];
  exp_t me, me8;
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  int   issued = 0, done_cnt = 0, issued8 = 0, done8 = 0;
  int   lat, lat8;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_lat(input string name, input int l, input int exact, input int maxc);
    n_cmp++;
    if ((exact > 0 && l != exact) || (exact == 0 && l > maxc)) begin
      n_bad++;
      $display("FAIL %s: got %0d cycles, expected %0d (max %0d)", name, l, exact, maxc);
    end
  endtask

  // Monitor for the 256-bit instance.
  always @(negedge clk) begin
    if (ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: got c=0x%0h err=%0b, expected no ready", c, err);
      end else begin
        me  = sb.pop_front();
        lat = cyc - me.acc;
        check("c", c, me.c);
        check("err", {255'd0, err}, {255'd0, me.err});
        check_lat("latency", lat, me.exact, me.maxc);
      end
      done_cnt++;
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (ready8) begin
      if (sb8.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready8: got c=0x%0h, expected no ready", c8);
      end else begin
        me8  = sb8.pop_front();
        lat8 = cyc - me8.acc;
        check("c8", {248'd0, c8}, me8.c);
        check("err8", {255'd0, err8}, {255'd0, me8.err});
        check_lat("latency8", lat8, me8.exact, me8.maxc);
      end
      done8++;
    end
  end

  task automatic issue(input logic [255:0] ai, bi, mi, ce, input logic ee, input int exact, input int maxc);
    @(negedge clk);
    a = ai; b = bi; m = mi; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{ce, ee, cyc, exact, maxc});
    issued++;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt < issued && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt < issued) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got %0d results, expected %0d", done_cnt, issued);
      done_cnt = issued;
      sb.delete();
    end
  endtask

  task automatic issue8(input int ai, input int bi);
    int ce = 0;
    for (int k = 0; k < 251; k++) begin
      if ((k * ai) % 251 == bi) ce = k;
    end
    @(negedge clk);
    a8 = 8'(ai); b8 = 8'(bi); m8 = 8'd251; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    sb8.push_back('{256'(ce), 1'b0, cyc, 0, 33});
    issued8++;
    for (int t = 0; t < 100 && done8 < issued8; t++) @(negedge clk);
    if (done8 < issued8) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout8: got %0d results, expected %0d", done8, issued8);
      done8 = issued8;
      sb8.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start8 = 1'b0;
    a = '0; b = '0; m = '0; a8 = '0; b8 = '0; m8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_c", c, 256'd0);
    check("rst_ready", {255'd0, ready}, 256'd0);
    check("rst_busy", {255'd0, busy}, 256'd0);
    check("rst_err", {255'd0, err}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Minimum latency: busy for one cycle, ready on the next.
    issue(256'd1 , 256'hbe, 256'd367, 256'hbe, 1'b0, 1, 0);
    check("busy_after_start", {255'd0, busy}, 256'd1);
    @(posedge clk);
    #1;
    check("busy_in_ready", {255'd0, busy}, 256'd0);
    check("ready_pulse", {255'd0, ready}, 256'd1);
    wait_done();

    issue(256'd2, 256'd1, 256'd367, 256'd184, 1'b0, 0, 1025);
    wait_done();

    // Starts while busy must be ignored.
    issue(256'd3, 256'hbe, 256'd367, 256'd308, 1'b0, 0, 1025);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy) begin
        a = 256'd5; b = 256'd7; m = 256'd11; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    wait_done();

    issue(256'd6, 256'd1, 256'd9, 256'd0, 1'b1, 0, 1025);
    wait_done();
    repeat (3) @(negedge clk);
    check("err_held", {255'd0, err}, 256'd1);
    check("c_held", c, 256'd0);

    issue(256'd0, 256'd5, 256'd367, 256'd0, 1'b1, 1, 0);
    wait_done();
`ifdef MOD_DIV_INPUT_CHECK_EN
    issue(256'd1, 256'd5, 256'd366, 256'd0, 1'b1, 1, 0);
    wait_done();
    issue(256'd5, 256'd400, 256'd367, 256'd0, 1'b1, 1, 0);
    wait_done();
`else
    issue(256'd1, 256'd5, 256'd367, 256'd5, 1'b0, 1, 0);
    wait_done();
`endif

    // Back-to-back: start held from the ready cycle is taken one cycle later.
    issue(256'd1, 256'd7, 256'd367, 256'd7, 1'b0, 1, 0);
    for (int t = 0; t < 10 && !ready; t++) @(negedge clk);
    a = 256'd2; b = 256'd1; m = 256'd367; start = 1'b1;
    @(posedge clk);
    #1;
    check("dead_cycle_busy", {255'd0, busy}, 256'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{256'd184, 1'b0, cyc, 0, 1025});
    issued++;
    wait_done();

    // Reset mid-run discards the request.
    issue(256'd3, 256'hbe, 256'd367, 256'd308, 1'b0, 0, 1025);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    issued = done_cnt;
    #1;
    check("abort_c", c, 256'd0);
    check("abort_busy", {255'd0, busy}, 256'd0);
    check("abort_err", {255'd0, err}, 256'd0);
    check("abort_ready", {255'd0, ready}, 256'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue(256'd3, 256'hbe, 256'd367, 256'd308, 1'b0, 0, 1025);
    wait_done();

    // Modulus-251 sweep on the 8-bit instance.
    for (int ai = 1; ai <= 250; ai++) begin
      issue8(ai, (ai * 37 + 11) % 251);
      if (ai % 50 == 0) issue8(ai, 0);
      if (ai % 50 == 1) issue8(ai, 250);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
